// File: rtl/prog_frame_loader.sv
// Framed, checksummed program loader: parses WRITE/END frames from the UART byte stream,
// writes ICCM words and holds the core in reset until a valid END frame closes the session.
module prog_frame_loader #(
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned MAX_WORDS      = 1024,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              prog_i,
    input  logic              rx_dv_i,
    input  logic [7:0]        rx_byte_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       wdata_o,
    output logic              prog_rst_no,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);
    localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W:0]   LIMIT    = (ADDR_W + 1)'(MAX_WORDS);

    typedef enum logic [3:0] {
        S_IDLE, S_SYNC, S_CMD, S_ADDR_HI, S_ADDR_LO, S_LEN, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t            state, nxt;
    logic [1:0]        nxt_code, code;
    logic [7:0]        addr_hi, addr_lo, len, idx, chk;
    logic [1:0]        bcnt;
    logic [23:0]       shreg;
    logic              is_end;
    logic [CNT_W-1:0]  cnt;
    logic [15:0]       addr_full;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   end_sum;
    logic              upper_set, in_frame, timed_out, word_done;

    always_comb begin
        addr_full = {addr_hi, addr_lo};
        base      = ADDR_W'(addr_full);
        upper_set = (32'(addr_full) >> ADDR_W) != 32'd0;
        end_sum   = {1'b0, base} + (ADDR_W + 1)'(rx_byte_i);
        in_frame  = state inside {S_CMD, S_ADDR_HI, S_ADDR_LO, S_LEN, S_DATA, S_CHK};
        timed_out = in_frame && !rx_dv_i && (cnt == CNT_LAST);
        word_done = (state == S_DATA) && rx_dv_i && prog_i && (bcnt == 2'd3);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= nxt;
    end

    // Session abort (prog_i low) outranks timeout, which outranks byte handling.
    always_comb begin
        nxt      = state;
        nxt_code = 2'd0;
        case (state)
            S_IDLE:        if (prog_i) nxt = S_SYNC;
            S_DONE, S_ERR: if (!prog_i) nxt = S_IDLE;
            default: begin
                if (!prog_i) begin
                    nxt = S_IDLE;
                end else if (timed_out) begin
                    nxt      = S_ERR;
                    nxt_code = 2'd2;
                end else if (rx_dv_i) begin
                    case (state)
                        S_SYNC:    if (rx_byte_i == SYNC_BYTE) nxt = S_CMD;
                        S_CMD: begin
                            if (rx_byte_i == 8'h01)      nxt = S_ADDR_HI;
                            else if (rx_byte_i == 8'h02) nxt = S_CHK;
                            else                         nxt = S_ERR;
                        end
                        S_ADDR_HI: nxt = S_ADDR_LO;
                        S_ADDR_LO: nxt = S_LEN;
                        S_LEN: begin
                            if (rx_byte_i == 8'h00) begin
                                nxt = S_ERR;
                            end else if (upper_set || (end_sum > LIMIT)) begin
                                nxt      = S_ERR;
                                nxt_code = 2'd3;
                            end else begin
                                nxt = S_DATA;
                            end
                        end
                        S_DATA:    if (bcnt == 2'd3 && idx == len - 8'd1) nxt = S_CHK;
                        S_CHK: begin
                            if (rx_byte_i == chk) begin
                                nxt = is_end ? S_DONE : S_SYNC;
                            end else begin
                                nxt      = S_ERR;
                                nxt_code = 2'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_o    <= 1'b0;
            addr_o  <= '0;
            wdata_o <= '0;
            code    <= '0;
            cnt     <= '0;
            addr_hi <= '0;
            addr_lo <= '0;
            len     <= '0;
            idx     <= '0;
            chk     <= '0;
            bcnt    <= '0;
            shreg   <= '0;
            is_end  <= 1'b0;
        end else begin
            we_o <= word_done;
            if (word_done) begin
                addr_o  <= base + ADDR_W'(idx);
                wdata_o <= {rx_byte_i, shreg};
            end
            cnt <= (!in_frame || rx_dv_i) ? '0 : cnt + 1'b1;
            if (nxt == S_ERR && state != S_ERR) code <= nxt_code;
            if (rx_dv_i && prog_i) begin
                case (state)
                    S_CMD: begin
                        chk    <= rx_byte_i;
                        is_end <= (rx_byte_i == 8'h02);
                    end
                    S_ADDR_HI: begin
                        addr_hi <= rx_byte_i;
                        chk     <= chk ^ rx_byte_i;
                    end
                    S_ADDR_LO: begin
                        addr_lo <= rx_byte_i;
                        chk     <= chk ^ rx_byte_i;
                    end
                    S_LEN: begin
                        len  <= rx_byte_i;
                        chk  <= chk ^ rx_byte_i;
                        idx  <= '0;
                        bcnt <= '0;
                    end
                    S_DATA: begin
                        chk   <= chk ^ rx_byte_i;
                        shreg <= {rx_byte_i, shreg[23:8]};
                        bcnt  <= bcnt + 2'd1;
                        if (bcnt == 2'd3) idx <= idx + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        prog_rst_no = (state == S_IDLE) || (state == S_DONE);
        done_o      = (state == S_DONE);
        err_o       = (state == S_ERR);
        err_code_o  = (state == S_ERR) ? code : 2'd0;
    end
endmodule

// File: tb/tb_prog_frame_loader.sv
// Bench for prog_frame_loader: directed frame scenarios plus random sessions scored
// against a byte-array frame parser.
module tb_prog_frame_loader;
    localparam int TO = 100;
    typedef logic [7:0] byte_q[$];

    logic        clk = 1'b0;
    logic        rst, prog, rx_dv;
    logic [7:0]  rx_byte;
    logic        we, prst_n, done, err;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [1:0]  code;

    int checks = 0;
    int failures = 0;

    logic [11:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [11:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_status;
    logic [1:0]  exp_code;
    byte_q       stim;

    always #5 clk = ~clk;

    prog_frame_loader #(.ADDR_W(12), .MAX_WORDS(1024), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst), .prog_i(prog), .rx_dv_i(rx_dv), .rx_byte_i(rx_byte),
        .we_o(we), .addr_o(addr), .wdata_o(wdata), .prog_rst_no(prst_n),
        .done_o(done), .err_o(err), .err_code_o(code)
    );

    always @(negedge clk) if (we) begin
        obs_addr.push_back(addr);
        obs_data.push_back(wdata);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired: bench did not finish");
        $fatal(1);
    end

    // Reference: walk the session byte array frame by frame. status 0 = session open, 1 = done, 2 = error.
    function automatic void model(input byte_q b);
        int unsigned i, n, base, len;
        logic [7:0]  x, cmd;
        exp_addr.delete();
        exp_data.delete();
        exp_status = 0;
        exp_code   = 2'd0;
        i = 0;
        n = b.size();
        while (i < n && exp_status == 0) begin
            if (b[i] != 8'hA5) begin i++; continue; end
            if (i + 1 >= n) break;
            cmd = b[i+1];
            x   = cmd;
            i  += 2;
            if (cmd == 8'h02) begin
                if (i >= n) break;
                if (b[i] == x) exp_status = 1;
                else begin exp_status = 2; exp_code = 2'd1; end
                break;
            end
            if (cmd != 8'h01) begin exp_status = 2; exp_code = 2'd0; break; end
            if (i + 3 > n) break;
            base = {b[i], b[i+1]};
            len  = b[i+2];
            x    = x ^ b[i] ^ b[i+1] ^ b[i+2];
            i   += 3;
            if (len == 0) begin exp_status = 2; exp_code = 2'd0; break; end
            if (base >= 4096 || base + len > 1024) begin exp_status = 2; exp_code = 2'd3; break; end
            if (i + 4 * len + 1 > n) break;
            for (int unsigned k = 0; k < len; k++) begin
                exp_addr.push_back(12'(base + k));
                exp_data.push_back({b[i+3], b[i+2], b[i+1], b[i]});
                x  = x ^ b[i] ^ b[i+1] ^ b[i+2] ^ b[i+3];
                i += 4;
            end
            if (b[i] != x) begin exp_status = 2; exp_code = 2'd1; break; end
            i++;
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_seq(input byte_q b);
        foreach (b[k]) send_byte(b[k], int'($urandom_range(0, 2)));
    endtask

    task automatic start_session();
        obs_addr.delete();
        obs_data.delete();
        prog = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic end_session();
        prog = 1'b0;
        repeat (3) @(negedge clk);
        obs_addr.delete();
        obs_data.delete();
    endtask

    task automatic add_write(input logic [15:0] a, input int len, input bit bad_chk);
        logic [7:0] x, d;
        stim.push_back(8'hA5);
        stim.push_back(8'h01);
        stim.push_back(a[15:8]);
        stim.push_back(a[7:0]);
        stim.push_back(8'(len));
        x = 8'h01 ^ a[15:8] ^ a[7:0] ^ 8'(len);
        for (int k = 0; k < 4 * len; k++) begin
            d = 8'($urandom);
            stim.push_back(d);
            x ^= d;
        end
        stim.push_back(bad_chk ? ~x : x);
    endtask

    task automatic test_reset();
        rst = 1'b1; prog = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({we, addr, wdata, prst_n, done, err, code} !== {1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL reset_state: got we=%b addr=%h wdata=%h prst_n=%b done=%b err=%b code=%0d, want 0 000 00000000 1 0 0 0",
                     we, addr, wdata, prst_n, done, err, code);
        end
    endtask

    task automatic test_write_and_end();
        byte_q f = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h32};
        start_session();
        foreach (f[k]) send_byte(f[k], 1);
        repeat (3) @(negedge clk);
        checks++;
        if (obs_addr.size() != 1) begin
            failures++; $display("FAIL write_count: got %0d want 1", obs_addr.size());
        end else begin
            checks++;
            if (obs_addr[0] !== 12'h010 || obs_data[0] !== 32'hDEADBEEF) begin
                failures++; $display("FAIL write_word: got %h/%h want 010/deadbeef", obs_addr[0], obs_data[0]);
            end
        end
        checks++;
        if (prst_n !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL write_status: got prst_n=%b err=%b done=%b want 0 0 0", prst_n, err, done);
        end
        send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h02, 1);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || prst_n !== 1'b1 || err !== 1'b0) begin
            failures++; $display("FAIL end_frame: got done=%b prst_n=%b err=%b want 1 1 0", done, prst_n, err);
        end
        end_session();
        checks++;
        if (done !== 1'b0 || prst_n !== 1'b1) begin
            failures++; $display("FAIL done_clear: got done=%b prst_n=%b want 0 1", done, prst_n);
        end
    endtask

    task automatic test_checksum_err();
        byte_q f = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h33};
        start_session();
        foreach (f[k]) send_byte(f[k], 1);
        repeat (3) @(negedge clk);
        checks++;
        if (obs_addr.size() != 1) begin
            failures++; $display("FAIL chk_err_writes: got %0d want 1", obs_addr.size());
        end
        checks++;
        if (err !== 1'b1 || code !== 2'd1 || prst_n !== 1'b0) begin
            failures++; $display("FAIL chk_err_status: got err=%b code=%0d prst_n=%b want 1 1 0", err, code, prst_n);
        end
        end_session();
        checks++;
        if (err !== 1'b0 || code !== 2'd0 || prst_n !== 1'b1) begin
            failures++; $display("FAIL err_clear: got err=%b code=%0d prst_n=%b want 0 0 1", err, code, prst_n);
        end
    endtask

    task automatic test_addr_overflow();
        start_session();
        send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h03, 1); send_byte(8'hFF, 1);
        send_byte(8'h02, 0);
        checks++;
        if (err !== 1'b1 || code !== 2'd3) begin
            failures++; $display("FAIL overflow_err: got err=%b code=%0d want 1 3", err, code);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (obs_addr.size() != 0) begin
            failures++; $display("FAIL overflow_writes: got %0d want 0", obs_addr.size());
        end
        end_session();
    endtask

    task automatic test_timeout();
        start_session();
        send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h00, 0);
        repeat (TO - 1) @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            failures++; $display("FAIL timeout_early: got err=%b want 0 one cycle before limit", err);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || code !== 2'd2) begin
            failures++; $display("FAIL timeout_err: got err=%b code=%0d want 1 2", err, code);
        end
        end_session();
    endtask

    task automatic test_prog_drop();
        byte_q f = '{8'hA5, 8'h01, 8'h00, 8'h20, 8'h01, 8'h11, 8'h22};
        start_session();
        foreach (f[k]) send_byte(f[k], (k == f.size() - 1) ? 0 : 1);
        prog = 1'b0;
        @(negedge clk);
        checks++;
        if (prst_n !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL prog_drop_idle: got prst_n=%b err=%b done=%b want 1 0 0", prst_n, err, done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (obs_addr.size() != 0) begin
            failures++; $display("FAIL prog_drop_writes: got %0d want 0", obs_addr.size());
        end
        stim = '{};
        add_write(16'h0020, 1, 1'b0);
        model(stim);
        start_session();
        send_seq(stim);
        repeat (3) @(negedge clk);
        checks++;
        if (obs_addr.size() != 1 || obs_addr[0] !== exp_addr[0] || obs_data[0] !== exp_data[0]) begin
            failures++; $display("FAIL resume_word: got n=%0d %h/%h want 1 %h/%h", obs_addr.size(),
                                 (obs_addr.size() > 0) ? obs_addr[0] : 12'hx, (obs_data.size() > 0) ? obs_data[0] : 32'hx,
                                 exp_addr[0], exp_data[0]);
        end
        end_session();
    endtask

    task automatic test_rst_mid();
        byte_q f = '{8'hA5, 8'h01, 8'h00, 8'h40, 8'h01, 8'h11, 8'h22};
        start_session();
        foreach (f[k]) send_byte(f[k], (k == f.size() - 1) ? 0 : 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({we, addr, wdata, prst_n, done, err} !== {1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            failures++; $display("FAIL rst_mid_state: got we=%b addr=%h wdata=%h prst_n=%b done=%b err=%b",
                                 we, addr, wdata, prst_n, done, err);
        end
        send_byte(8'h33, 1); send_byte(8'h44, 1);
        repeat (3) @(negedge clk);
        checks++;
        if (obs_addr.size() != 0 || prst_n !== 1'b0) begin
            failures++; $display("FAIL rst_mid_after: got writes=%0d prst_n=%b want 0 0", obs_addr.size(), prst_n);
        end
        end_session();
    endtask

    task automatic test_random();
        int nf, len, r;
        logic [15:0] a;
        logic [7:0]  junk;
        for (int s = 0; s < 8; s++) begin
            stim = '{};
            nf = $urandom_range(1, 3);
            for (int f = 0; f < nf; f++) begin
                repeat ($urandom_range(0, 2)) begin
                    junk = 8'($urandom);
                    stim.push_back((junk == 8'hA5) ? 8'h00 : junk);
                end
                len = $urandom_range(1, 4);
                a   = 16'($urandom_range(0, 1023));
                if (a + len > 1024) a = 16'(1024 - len);
                r = $urandom_range(0, 11);
                if (r == 0) a = 16'(1025 - len);
                if (r == 2) a[12] = 1'b1;
                if (r == 3) len = 0;
                add_write(a, len, r == 1);
            end
            stim.push_back(8'hA5);
            stim.push_back(8'h02);
            stim.push_back(($urandom_range(0, 7) == 0) ? 8'h03 : 8'h02);
            model(stim);
            start_session();
            send_seq(stim);
            repeat (4) @(negedge clk);
            checks++;
            if (obs_addr.size() != exp_addr.size()) begin
                failures++; $display("FAIL rand_count[%0d]: got %0d want %0d", s, obs_addr.size(), exp_addr.size());
            end else begin
                foreach (exp_addr[k]) begin
                    checks++;
                    if (obs_addr[k] !== exp_addr[k] || obs_data[k] !== exp_data[k]) begin
                        failures++; $display("FAIL rand_word[%0d.%0d]: got %h/%h want %h/%h", s, k,
                                             obs_addr[k], obs_data[k], exp_addr[k], exp_data[k]);
                    end
                end
            end
            checks++;
            if ({done, err, code, prst_n} !== {exp_status == 1, exp_status == 2,
                                               (exp_status == 2) ? exp_code : 2'd0, exp_status == 1}) begin
                failures++; $display("FAIL rand_status[%0d]: got done=%b err=%b code=%0d prst_n=%b want status=%0d code=%0d",
                                     s, done, err, code, prst_n, exp_status, exp_code);
            end
            end_session();
        end
    endtask

    initial begin
        test_reset();
        test_write_and_end();
        test_checksum_err();
        test_addr_overflow();
        test_timeout();
        test_prog_drop();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
